// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// State encoding is visible to the bench as well as the RTL.
package serial_sub_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        SHIFT = S_SHIFT,
        DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin.
// Purely combinational; reused every cycle by the serial datapath.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, start/done handshake.
// Optional signed overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [N-1:0]  ra;
    logic [N-1:0]  rb;
    logic [N-1:0]  res;
    logic [CW-1:0] cnt;
    logic          borrow;
    logic          fd;
    logic          fbout;
    logic [N:0]    cat;
    logic [N-1:0]  nres;

    full_subtractor u_fs (
        .a    (ra[0]),
        .b    (rb[0]),
        .bin  (borrow),
        .d    (fd),
        .bout (fbout)
    );

    // Concatenate then drop the LSB so N = 1 needs no special case
    assign cat  = {fd, res};
    assign nres = cat[N:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            res    <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == SHIFT) begin
                ra     <= ra >> 1;
                rb     <= rb >> 1;
                res    <= nres;
                borrow <= fbout;
                cnt    <= cnt + CW'(1);
                if (cnt == LAST) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    d     <= nres;
                    bout  <= fbout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf   <= borrow ^ fbout;
`endif
                end
            end else if (start) begin
                state  <= SHIFT;
                ra     <= a;
                rb     <= b;
                res    <= '0;
                borrow <= bin;
                cnt    <= '0;
                busy   <= 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic reference model plus directed vectors.
// Overflow checks are active when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       bout;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
    logic       ovf1;
`endif

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       bin1 = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] d1;
    logic       bout1;

    int pass = 0;
    int total = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.N(8)) u8 (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_subtractor #(.N(1)) u1 (
        .clk   (clk),
        .reset (reset),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .d     (d1),
        .bout  (bout1)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t",
                      nm, act, exp, $time);
    endtask

    function automatic logic [7:0] f_d(logic [7:0] x, logic [7:0] y,
                                       logic c);
        int r;
        r = int'(x) - int'(y) - int'(c);
        return r[7:0];
    endfunction

    function automatic logic f_b(logic [7:0] x, logic [7:0] y, logic c);
        return int'(x) < int'(y) + int'(c);
    endfunction

    function automatic logic f_o(logic [7:0] x, logic [7:0] y, logic c);
        int r;
        r = int'($signed(x)) - int'($signed(y)) - int'(c);
        return (r < -128) || (r > 127);
    endfunction

    // Reference model: an accepted request yields its arithmetic
    // result exactly N+1 cycles later; requests while busy are dropped.
    int         m_left;
    logic       m_done;
    logic [7:0] m_d;
    logic       m_b;
    logic       m_o;
    logic [7:0] p_d;
    logic       p_b;
    logic       p_o;

    always @(posedge clk) begin
        if (reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_d    <= '0;
            m_b    <= 1'b0;
            m_o    <= 1'b0;
        end else begin
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_d <= p_d;
                m_b <= p_b;
                m_o <= p_o;
            end
            if (m_left != 0) begin
                m_left <= m_left - 1;
            end else if (start) begin
                m_left <= 8;
                p_d    <= f_d(a, b, bin);
                p_b    <= f_b(a, b, bin);
                p_o    <= f_o(a, b, bin);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_busy", 32'(busy), 32'(m_left != 0));
            chk("mdl_done", 32'(done), 32'(m_done));
            chk("mdl_d", 32'(d), 32'(m_d));
            chk("mdl_bout", 32'(bout), 32'(m_b));
`ifdef SERIAL_SUB_OVF_EN
            chk("mdl_ovf", 32'(ovf), 32'(m_o));
`endif
        end
    end

    task automatic wait_done(output int c);
        c = 1;
        while (!done && c < 20) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic run_op(input string nm, input logic [7:0] ia,
                          input logic [7:0] ib, input logic ic,
                          input logic [7:0] ed, input logic eb,
                          input logic eo);
        int c;
        @(negedge clk);
        a = ia;
        b = ib;
        bin = ic;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        bin = 1'($urandom);
        wait_done(c);
        chk({nm, "_lat"}, 32'(c), 32'd9);
        chk({nm, "_d"}, 32'(d), 32'(ed));
        chk({nm, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected X in vector %s", nm);
`endif
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        run_op("v200_55", 8'd200, 8'd55, 1'b0, 8'd145, 1'b0, 1'b0);
        run_op("v10_20", 8'd10, 8'd20, 1'b0, 8'd246, 1'b1, 1'b0);
        run_op("v0_0_1", 8'd0, 8'd0, 1'b1, 8'd255, 1'b1, 1'b0);
        run_op("v80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("v05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op("eq_b0", 8'd77, 8'd77, 1'b0, 8'd0, 1'b0, 1'b0);
        run_op("eq_b1", 8'd77, 8'd77, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("v7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // start held through SHIFT with new operands, then DONE->SHIFT
        @(negedge clk);
        a = 8'd200;
        b = 8'd55;
        bin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        a = 8'd1;
        b = 8'd2;
        wait_done(c);
        chk("hold_lat", 32'(c), 32'd9);
        chk("hold_d", 32'(d), 32'd145);
        @(negedge clk);
        chk("b2b_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(c);
        chk("b2b_lat", 32'(c), 32'd9);
        chk("b2b_d", 32'(d), 32'd255);
        chk("b2b_bout", 32'(bout), 32'd1);

        // reset in the middle of an operation
        @(negedge clk);
        a = 8'd200;
        b = 8'd55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_d", 32'(d), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        c = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) c++;
        end
        chk("abort_nodone", 32'(c), 32'd0);
        run_op("after_rst", 8'd5, 8'd3, 1'b0, 8'd2, 1'b0, 1'b0);

        // N = 1 instance
        @(negedge clk);
        a1 = 1'b0;
        b1 = 1'b1;
        bin1 = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("n1_busy", 32'(busy1), 32'd1);
        chk("n1_done0", 32'(done1), 32'd0);
        @(negedge clk);
        chk("n1_done", 32'(done1), 32'd1);
        chk("n1_d", 32'(d1), 32'd1);
        chk("n1_bout", 32'(bout1), 32'd1);
        @(negedge clk);
        chk("n1_pulse", 32'(done1), 32'd0);
        chk("n1_hold", 32'(d1), 32'd1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
